// File: rtl/mul_pkg.sv
// Shared types and elaboration helpers for the wallace_mul pipeline.
// Holds the operation encoding, the control part of every stage register
// and the constant functions that size the carry-save reduction tree.
package mul_pkg;

   // Operation encoding (RISC-V M-extension multiply flavours).
   typedef enum logic [1:0] {
      MUL    = 2'd0,
      MULH   = 2'd1,
      MULHSU = 2'd2,
      MULHU  = 2'd3
   } mul_op_t;

   // Control carried by every pipeline stage alongside its data.
   typedef struct packed {
      logic    valid;
      mul_op_t op;
   } stage_ctl_t;

   // Rows left after one layer of 3:2 compression: each full group of
   // three becomes two, leftovers pass straight through.
   function automatic int csa_rows_next(input int n);
      return (n / 3) * 2 + (n % 3);
   endfunction

   // Rows present at the input of reduction layer lvl.
   function automatic int csa_rows_at(input int n, input int lvl);
      int rows;
      rows = n;
      for (int i = 0; i < lvl; i++) begin
         rows = csa_rows_next(rows);
      end
      return rows;
   endfunction

   // Number of 3:2 layers needed to bring n rows down to two.
   function automatic int csa_levels(input int n);
      int rows;
      int lvl;
      rows = n;
      lvl  = 0;
      while (rows > 2) begin
         rows = csa_rows_next(rows);
         lvl++;
      end
      return lvl;
   endfunction

endpackage

// File: rtl/csa_row.sv
// One row of full-adder 3:2 compressors. Three N-bit addends become a sum
// vector and a carry vector whose total equals the three inputs modulo 2^N.
// The carry vector is already weight-aligned (shifted left by one), so the
// caller can add it directly; the carry out of bit N-1 is dropped.
module csa_row #(
   parameter int N = 8
) (
   input  logic [N-1:0] i_x,
   input  logic [N-1:0] i_y,
   input  logic [N-1:0] i_z,
   output logic [N-1:0] o_sum,
   output logic [N-1:0] o_carry
);

   // Per-bit full adders: parity for the sum, majority for the carry.
   always_comb begin
      o_sum   = i_x ^ i_y ^ i_z;
      o_carry = ((i_x & i_y) | (i_x & i_z) | (i_y & i_z)) << 1;
   end

endmodule

// File: rtl/wallace_mul.sv
// wallace_mul: 3-stage pipelined multiplier supporting MUL/MULH/MULHSU/MULHU.
//   S1 register: extended-operand partial products.
//   S2 register: two carry-save rows after the Wallace 3:2 tree.
//   S3 register: carry-propagated product, selected result bits.
// Optional flush port compiled in with `define WALLACE_MUL_FLUSH_EN.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a response transfers on a rising edge where out_valid && out_ready. While
// out_valid is high and out_ready is low, out_valid and result hold. Each
// stage moves forward when the stage after it is empty or moving itself, so
// the only source of back-pressure is out_ready.
module wallace_mul
   import mul_pkg::*;
#(
   parameter int WIDTH = 32  // even, 8..64
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef WALLACE_MUL_FLUSH_EN
   input  logic             flush,
`endif
   input  mul_op_t          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result
);

   // Extended operands are WIDTH+1 bits; their product needs 2*WIDTH+2 bits.
   localparam int P    = 2 * WIDTH + 2;
   // WIDTH shifted copies of a, one negated sign row, one +1 correction row.
   localparam int NR   = WIDTH + 2;
   localparam int LVLS = csa_levels(NR);

   typedef struct packed {
      stage_ctl_t        ctl;
      logic [NR*P-1:0]   pp;
   } s1_reg_t;

   typedef struct packed {
      stage_ctl_t        ctl;
      logic [P-1:0]      sum;
      logic [P-1:0]      carry;
   } s2_reg_t;

   // The op has been consumed by the result select, so S3 drops it.
   typedef struct packed {
      logic              valid;
      logic [WIDTH-1:0]  res;
   } s3_reg_t;

   s1_reg_t r_s1;
   s2_reg_t r_s2;
   s3_reg_t r_s3;

   logic             w_flush;
   logic             w_s1_free;
   logic             w_s2_free;
   logic             w_s3_free;
   logic             w_accept;

   logic             w_a_sx;
   logic             w_b_sx;
   logic [WIDTH:0]   w_a_ext;
   logic [WIDTH:0]   w_b_ext;
   logic [P-1:0]     w_a_row;
   logic [NR*P-1:0]  w_pp;

   logic [P-1:0]     w_tree_sum;
   logic [P-1:0]     w_tree_carry;

   logic [P-1:0]     w_prod;
   logic [WIDTH-1:0] w_res;
   logic             w_unused_prod_hi;

`ifdef WALLACE_MUL_FLUSH_EN
   assign w_flush = flush;
`else
   assign w_flush = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // Flow control
   // ---------------------------------------------------------------------
   assign w_s3_free = !r_s3.valid     || out_ready;
   assign w_s2_free = !r_s2.ctl.valid || w_s3_free;
   assign w_s1_free = !r_s1.ctl.valid || w_s2_free;

   // Refuse new work during a flush cycle so nothing survives it.
   assign in_ready  = w_s1_free && !w_flush;
   assign w_accept  = in_valid && in_ready;

   assign out_valid = r_s3.valid;
   assign result    = r_s3.res;

   // ---------------------------------------------------------------------
   // S1: operand extension and partial-product generation
   // ---------------------------------------------------------------------
   // Rows 0..WIDTH-1 add b[i] * a_ext * 2^i. The extended b's top bit has
   // weight -2^WIDTH, so its row is -a_ext * 2^WIDTH, split into the
   // inverted row plus a single correction bit at position WIDTH.
   always_comb begin
      w_a_sx  = (op == MULH) || (op == MULHSU);
      w_b_sx  = (op == MULH);
      w_a_ext = {w_a_sx & a[WIDTH-1], a};
      w_b_ext = {w_b_sx & b[WIDTH-1], b};
      w_a_row = {{(P-WIDTH-1){w_a_ext[WIDTH]}}, w_a_ext};
      w_pp    = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_pp[i*P +: P] = w_b_ext[i] ? (w_a_row << i) : '0;
      end
      w_pp[WIDTH*P +: P]           = w_b_ext[WIDTH] ? (~w_a_row << WIDTH) : '0;
      w_pp[(WIDTH+1)*P + WIDTH]    = w_b_ext[WIDTH];
   end

   // ---------------------------------------------------------------------
   // S2: Wallace reduction of the registered rows down to sum + carry
   // ---------------------------------------------------------------------
   for (genvar l = 0; l < LVLS; l++) begin : g_lvl
      localparam int N_IN  = csa_rows_at(NR, l);
      localparam int N_OUT = csa_rows_at(NR, l + 1);
      localparam int N_GRP = N_IN / 3;

      logic [N_IN*P-1:0]  w_in;
      logic [N_OUT*P-1:0] w_out;

      if (l == 0) begin : g_src
         assign w_in = r_s1.pp;
      end else begin : g_src
         assign w_in = g_lvl[l-1].w_out;
      end

      // Each group of three rows collapses into a sum row and a carry row.
      for (genvar g = 0; g < N_GRP; g++) begin : g_grp
         csa_row #(
            .N(P)
         ) u_csa (
            .i_x    (w_in[(3*g)*P +: P]),
            .i_y    (w_in[(3*g+1)*P +: P]),
            .i_z    (w_in[(3*g+2)*P +: P]),
            .o_sum  (w_out[(2*g)*P +: P]),
            .o_carry(w_out[(2*g+1)*P +: P])
         );
      end

      // Leftover rows (one or two) ride to the next layer untouched.
      for (genvar r = 3 * N_GRP; r < N_IN; r++) begin : g_pass
         assign w_out[(r-N_GRP)*P +: P] = w_in[r*P +: P];
      end
   end

   assign w_tree_sum   = g_lvl[LVLS-1].w_out[P-1:0];
   assign w_tree_carry = g_lvl[LVLS-1].w_out[2*P-1:P];

   // ---------------------------------------------------------------------
   // S3: carry-propagate add and result select
   // ---------------------------------------------------------------------
   // The top two product bits only matter for the full-width signed value;
   // no operation selects them.
   always_comb begin
      w_prod           = r_s2.sum + r_s2.carry;
      w_res            = (r_s2.ctl.op == MUL) ? w_prod[WIDTH-1:0]
                                              : w_prod[2*WIDTH-1:WIDTH];
      w_unused_prod_hi = ^w_prod[P-1:2*WIDTH];
   end

   // ---------------------------------------------------------------------
   // Stage registers: each stage loads when its successor can take its
   // contents; flush and reset both empty every stage.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= '0;
         r_s2 <= '0;
         r_s3 <= '0;
      end else begin
         if (w_s1_free) begin
            r_s1.ctl.valid <= w_accept;
            r_s1.ctl.op    <= op;
            r_s1.pp        <= w_pp;
         end
         if (w_s2_free) begin
            r_s2.ctl   <= r_s1.ctl;
            r_s2.sum   <= w_tree_sum;
            r_s2.carry <= w_tree_carry;
         end
         if (w_s3_free) begin
            r_s3.valid <= r_s2.ctl.valid;
            r_s3.res   <= w_res;
         end
         if (w_flush) begin
            r_s1.ctl.valid <= 1'b0;
            r_s2.ctl.valid <= 1'b0;
            r_s3.valid     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wallace_mul.sv
// Self-checking bench for wallace_mul: directed corner cases and latency at
// WIDTH=32, back-pressure, reset mid-flight, optional flush, then random
// traffic on a WIDTH=32 and a WIDTH=8 instance against a plain-arithmetic
// reference model.
module tb_wallace_mul;
   import mul_pkg::*;

   // ------------------------------------------------------------------
   // Clock / reset
   // ------------------------------------------------------------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ------------------------------------------------------------------
   // DUT signals
   // ------------------------------------------------------------------
   mul_op_t     op_i = MUL;
   logic [31:0] a_i = '0;
   logic [31:0] b_i = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic        flush_i = 1'b0;
   logic [31:0] cur_exp = '0;

   mul_op_t     op8 = MUL;
   logic [7:0]  a8 = '0;
   logic [7:0]  b8 = '0;
   logic        in_valid8 = 1'b0;
   logic        in_ready8;
   logic        out_valid8;
   logic        out_ready8 = 1'b1;
   logic [7:0]  result8;
   logic [7:0]  cur_exp8 = '0;

   wallace_mul #(
      .WIDTH(32)
   ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
`ifdef WALLACE_MUL_FLUSH_EN
      .flush    (flush_i),
`endif
      .op       (op_i),
      .a        (a_i),
      .b        (b_i),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result)
   );

   wallace_mul #(
      .WIDTH(8)
   ) u_dut8 (
      .clk      (clk),
      .rst_n    (rst_n),
`ifdef WALLACE_MUL_FLUSH_EN
      .flush    (1'b0),
`endif
      .op       (op8),
      .a        (a8),
      .b        (b8),
      .in_valid (in_valid8),
      .in_ready (in_ready8),
      .out_valid(out_valid8),
      .out_ready(out_ready8),
      .result   (result8)
   );

   // ------------------------------------------------------------------
   // Checking
   // ------------------------------------------------------------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: extend per op, multiply as integers, pick the bit field.
   function automatic logic [63:0] ref_mul(input mul_op_t o, input logic [63:0] x,
                                           input logic [63:0] y, input int w);
      logic [131:0] mask;
      logic [131:0] ex;
      logic [131:0] ey;
      logic [131:0] p;
      logic [131:0] r;
      logic         sx;
      logic         sy;
      sx   = (o == MULH) || (o == MULHSU);
      sy   = (o == MULH);
      mask = (132'd1 << w) - 132'd1;
      ex   = {68'd0, x} & mask;
      ey   = {68'd0, y} & mask;
      if (sx && x[w-1]) ex = ex - (132'd1 << w);
      if (sy && y[w-1]) ey = ey - (132'd1 << w);
      p = ex * ey;
      if (o == MUL) r = p & mask;
      else          r = (p >> w) & mask;
      return r[63:0];
   endfunction

   function automatic logic [63:0] pick(input int w);
      logic [63:0] ones;
      logic [63:0] v;
      ones = (64'd1 << w) - 64'd1;
      case ($urandom_range(0, 5))
         0:       v = 64'd0;
         1:       v = ones;
         2:       v = 64'd1 << (w - 1);
         default: v = {$urandom, $urandom} & ones;
      endcase
      return v;
   endfunction

   // ------------------------------------------------------------------
   // Scoreboards (sampled 1 time unit before each rising edge)
   // ------------------------------------------------------------------
   logic [31:0] exp_q[$];
   int          acc_q[$];
   int          acc_cnt = 0;
   logic        lat_chk = 1'b0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_res = '0;

   always @(negedge clk) begin
      logic [31:0] e;
      int          c;
      #4;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_result", result, prev_res);
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(cur_exp);
            acc_q.push_back(cyc);
            acc_cnt++;
         end
         if (out_valid && out_ready) begin
            check("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               c = acc_q.pop_front();
               check("result", result, e);
               if (lat_chk) check("latency", cyc - c, 3);
            end
         end
         prev_stall = out_valid && !out_ready && !flush_i;
         prev_res   = result;
      end
   end

   logic [7:0]  exp8_q[$];
   logic        prev_stall8 = 1'b0;
   logic [7:0]  prev_res8 = '0;

   always @(negedge clk) begin
      logic [7:0] e;
      #4;
      if (!rst_n) begin
         prev_stall8 = 1'b0;
      end else begin
         if (prev_stall8) begin
            check("hold_valid8", out_valid8, 1);
            check("hold_result8", result8, prev_res8);
         end
         if (in_valid8 && in_ready8) exp8_q.push_back(cur_exp8);
         if (out_valid8 && out_ready8) begin
            check("sb_nonempty8", exp8_q.size() != 0, 1);
            if (exp8_q.size() != 0) begin
               e = exp8_q.pop_front();
               check("result8", result8, e);
            end
         end
         prev_stall8 = out_valid8 && !out_ready8;
         prev_res8   = result8;
      end
   end

   // ------------------------------------------------------------------
   // Driver tasks
   // ------------------------------------------------------------------
   task automatic send(input mul_op_t o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] e);
      @(negedge clk);
      op_i     = o;
      a_i      = x;
      b_i      = y;
      cur_exp  = e;
      in_valid = 1'b1;
      for (int t = 0; t < 100; t++) begin
         #4;
         if (in_ready) begin
            @(posedge clk);
            return;
         end
         @(negedge clk);
      end
      check("send_timeout", 0, 1);
   endtask

   task automatic send_rand();
      mul_op_t     o;
      logic [31:0] x;
      logic [31:0] y;
      o = mul_op_t'($urandom_range(0, 3));
      x = 32'(pick(32));
      y = 32'(pick(32));
      send(o, x, y, 32'(ref_mul(o, {32'd0, x}, {32'd0, y}, 32)));
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk);
      check("drain_empty", exp_q.size(), 0);
   endtask

   task automatic drain8();
      for (int t = 0; t < 200 && exp8_q.size() != 0; t++) @(posedge clk);
      check("drain_empty8", exp8_q.size(), 0);
   endtask

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      int   base;
      int   stale;
      logic took;

      // Reset state
      #3;
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_out_valid8", out_valid8, 0);
      check("rst_result8", result8, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #4;
      check("rst_in_ready", in_ready, 1);
      check("rst_in_ready8", in_ready8, 1);

      // Corner operands, latency 3 with out_ready held high
      lat_chk   = 1'b1;
      out_ready = 1'b1;
      send(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      idle();
      drain();
      send(MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
      send(MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
      send(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      send(MULHU,  32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
      send(MUL,    32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
      idle();
      drain();

      // Four back-to-back mixed ops: outputs on consecutive cycles 3..6
      send(MUL,   32'd3,         32'd5,         32'd15);
      send(MULH,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF);
      send(MULHU, 32'd0,         $urandom,      32'd0);
      send(MUL,   32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFF9);
      idle();
      drain();

      // Back-pressure: out_ready low for 5 cycles with in_valid held high
      lat_chk = 1'b0;
      @(negedge clk);
      out_ready = 1'b0;
      base = acc_cnt;
      took = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (k != 0) @(negedge clk);
         if (took) begin
            op_i     = mul_op_t'($urandom_range(0, 3));
            a_i      = 32'(pick(32));
            b_i      = 32'(pick(32));
            cur_exp  = 32'(ref_mul(op_i, {32'd0, a_i}, {32'd0, b_i}, 32));
         end
         in_valid = 1'b1;
         #4;
         took = in_valid && in_ready;
      end
      @(posedge clk);
      #1;
      check("stall_accepts", acc_cnt - base, 3);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();

      // Reset with two requests in flight
      lat_chk = 1'b1;
      send_rand();
      send_rand();
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_result", result, 0);
      exp_q.delete();
      acc_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #4;
      check("midrst_in_ready", in_ready, 1);
      stale = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         #4;
         if (out_valid) stale++;
      end
      check("midrst_no_stale", stale, 0);
      send_rand();
      idle();
      drain();

`ifdef WALLACE_MUL_FLUSH_EN
      // Flush a full, stalled pipeline
      lat_chk   = 1'b0;
      @(negedge clk);
      out_ready = 1'b0;
      send_rand();
      send_rand();
      send_rand();
      @(negedge clk);
      base     = acc_cnt;
      in_valid = 1'b1;
      flush_i  = 1'b1;
      #4;
      check("flush_in_ready", in_ready, 0);
      @(posedge clk);
      exp_q.delete();
      acc_q.delete();
      #1;
      check("flush_out_valid", out_valid, 0);
      check("flush_no_accept", acc_cnt - base, 0);
      @(negedge clk);
      flush_i   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      lat_chk   = 1'b1;
      send(MUL, 32'd6, 32'd7, 32'd42);
      idle();
      drain();
`endif

      // Random traffic, WIDTH=32, random back-pressure
      lat_chk = 1'b0;
      took    = 1'b0;
      in_valid = 1'b0;
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         if (!in_valid || took) begin
            in_valid = ($urandom_range(0, 3) != 0);
            op_i     = mul_op_t'($urandom_range(0, 3));
            a_i      = 32'(pick(32));
            b_i      = 32'(pick(32));
            cur_exp  = 32'(ref_mul(op_i, {32'd0, a_i}, {32'd0, b_i}, 32));
         end
         out_ready = ($urandom_range(0, 3) != 0);
         #4;
         took = in_valid && in_ready;
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();

      // Random traffic, WIDTH=8
      took = 1'b0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (!in_valid8 || took) begin
            in_valid8 = ($urandom_range(0, 3) != 0);
            op8       = mul_op_t'($urandom_range(0, 3));
            a8        = 8'(pick(8));
            b8        = 8'(pick(8));
            cur_exp8  = 8'(ref_mul(op8, {56'd0, a8}, {56'd0, b8}, 8));
         end
         out_ready8 = ($urandom_range(0, 3) != 0);
         #4;
         took = in_valid8 && in_ready8;
      end
      @(negedge clk);
      in_valid8  = 1'b0;
      out_ready8 = 1'b1;
      drain8();

      // Report
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Hard stop if anything above wedges.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
